// File: rtl/uc_intc_pkg.sv
// uc_intc_pkg: shared types and constants for the uc_intc interrupt controller.
// FSM encoding, interrupt id width and the default vector layout live here.
package uc_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Wide enough for up to 8 request lines.
    localparam int IRQ_ID_W = 3;

    localparam logic [9:0] DEF_VEC_BASE   = 10'h3F0;
    localparam int         DEF_VEC_STRIDE = 4;

    localparam int TMR_W = 16;

endpackage

// File: rtl/uc_intc_if.sv
// uc_intc_if: request/mask/return inputs and dispatch outputs of uc_intc.
// The master side drives requests, mask writes and fin_interrup; the slave
// side (the controller) drives s_interrup, vector, id, busy, pending and a
// debug copy of its FSM state.
// Handshake: s_interrup is a one-cycle entry pulse with vec_addr/irq_id valid
// in that cycle; the controller then stays busy until the master pulses
// fin_interrup, which is only honoured while busy and not in the entry cycle.
interface uc_intc_if #(
    parameter int N_IRQ = 4,
    parameter int VEC_W = 10
) ();
    import uc_intc_pkg::*;

    logic [N_IRQ-1:0]    irq_i;
    logic                mask_we;
    logic [N_IRQ-1:0]    mask_d;
    logic                fin_interrup;
    logic                s_interrup;
    logic [VEC_W-1:0]    vec_addr;
    logic [IRQ_ID_W-1:0] irq_id;
    logic                busy;
    logic [N_IRQ-1:0]    pending;
    state_t              state_dbg;

    modport master (
        output irq_i, mask_we, mask_d, fin_interrup,
        input  s_interrup, vec_addr, irq_id, busy, pending, state_dbg
    );

    modport slave (
        input  irq_i, mask_we, mask_d, fin_interrup,
        output s_interrup, vec_addr, irq_id, busy, pending, state_dbg
    );

endinterface

// File: rtl/uc_intc_timer.sv
// uc_intc_timer: periodic down-counter feeding source 0 of uc_intc.
// Writing tmr_d loads both reload and count; a reload of 0 stops the timer.
module uc_intc_timer
    import uc_intc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tmr_we,
    input  logic [TMR_W-1:0] tmr_d,
    output logic             tick
);

    logic [TMR_W-1:0] reload;
    logic [TMR_W-1:0] count;

    // A tick is emitted in the cycle the running counter reaches 1.
    assign tick = !tmr_we && (reload != '0) && (count == TMR_W'(1));

    // Load on write, otherwise count down and wrap back to reload at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= '0;
            count  <= '0;
        end else if (tmr_we) begin
            reload <= tmr_d;
            count  <= tmr_d;
        end else if (reload != '0) begin
            if (count <= TMR_W'(1)) begin
                count <= reload;
            end else begin
                count <= count - TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uc_intc.sv
// uc_intc: interrupt controller between the I/O ports and the uc/PC mux.
// Rising edges on irq_i are latched as pending, masked, and dispatched by
// fixed priority (lowest index first) as a one-cycle s_interrup pulse with
// the vector PC. No further dispatch until fin_interrup returns to IDLE.
// Optional feature: define UC_INTC_TIMER_EN to add an internal periodic timer
// (ports tmr_we/tmr_d) whose tick is ORed into the edge of source 0.
module uc_intc
    import uc_intc_pkg::*;
#(
    parameter int               N_IRQ      = 4,
    parameter int               VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(DEF_VEC_BASE),
    parameter int               VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             rst_n,
    uc_intc_if.slave         bus
`ifdef UC_INTC_TIMER_EN
    ,
    input  logic             tmr_we,
    input  logic [TMR_W-1:0] tmr_d
`endif
);

    // Lowest set bit wins.
    function automatic logic [IRQ_ID_W-1:0] prio_sel(input logic [N_IRQ-1:0] req);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
        return id;
    endfunction

    // Vector address, wrapping modulo 2^VEC_W.
    function automatic logic [VEC_W-1:0] vec_of(input logic [IRQ_ID_W-1:0] id);
        return VEC_W'(32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE));
    endfunction

    logic [N_IRQ-1:0]    irq_prev;
    logic [N_IRQ-1:0]    mask;
    logic [N_IRQ-1:0]    pending_q;
    logic [N_IRQ-1:0]    edge_det;
    logic [N_IRQ-1:0]    clr;
    logic [N_IRQ-1:0]    avail;
    logic [IRQ_ID_W-1:0] sel_id;
    logic                tick;

    state_t              state;
    logic                s_int_q;
    logic                busy_q;
    logic [IRQ_ID_W-1:0] id_q;
    logic [VEC_W-1:0]    vec_q;

`ifdef UC_INTC_TIMER_EN
    uc_intc_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .tmr_we (tmr_we),
        .tmr_d  (tmr_d),
        .tick   (tick)
    );
`else
    assign tick = 1'b0;
`endif

    // Edge detect, timer tick merge, dispatch clear and selection.
    always_comb begin
        edge_det    = bus.irq_i & ~irq_prev;
        edge_det[0] = edge_det[0] | tick;
        clr         = (state == ST_REQ) ? (N_IRQ'(1) << id_q) : '0;
        avail       = pending_q & mask;
        sel_id      = prio_sel(avail);
    end

    // Request history, mask register and pending latch (a new edge beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev  <= '0;
            mask      <= '1;
            pending_q <= '0;
        end else begin
            irq_prev  <= bus.irq_i;
            pending_q <= (pending_q & ~clr) | edge_det;
            if (bus.mask_we) begin
                mask <= bus.mask_d;
            end
        end
    end

    // Dispatch FSM with registered outputs: IDLE -> REQ (1 cycle) -> SERVICE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            s_int_q <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= '0;
            vec_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (avail != '0) begin
                        state   <= ST_REQ;
                        s_int_q <= 1'b1;
                        busy_q  <= 1'b1;
                        id_q    <= sel_id;
                        vec_q   <= vec_of(sel_id);
                    end
                end
                ST_REQ: begin
                    state   <= ST_SERVICE;
                    s_int_q <= 1'b0;
                end
                ST_SERVICE: begin
                    if (bus.fin_interrup) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        id_q   <= '0;
                        vec_q  <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    s_int_q <= 1'b0;
                    busy_q  <= 1'b0;
                    id_q    <= '0;
                    vec_q   <= '0;
                end
            endcase
        end
    end

    assign bus.s_interrup = s_int_q;
    assign bus.vec_addr   = vec_q;
    assign bus.irq_id     = id_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = pending_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_uc_intc.sv
// tb_uc_intc: directed bench for uc_intc. A per-cycle vector table covers
// single dispatch, priority, masking, level/nesting and return handling;
// hand-written sequences cover asynchronous reset mid-service and, when
// UC_INTC_TIMER_EN is defined, the periodic timer.
module tb_uc_intc;
    import uc_intc_pkg::*;

    localparam int NROWS = 40;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    uc_intc_if #(.N_IRQ(4), .VEC_W(10)) bus ();

`ifdef UC_INTC_TIMER_EN
    logic        tmr_we;
    logic [15:0] tmr_d;
    uc_intc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .tmr_we (tmr_we),
        .tmr_d  (tmr_d)
    );
`else
    uc_intc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic       mon_en = 1'b1;

    // Every cycle with s_interrup high records the vector seen.
    always @(negedge clk) begin
        if (mon_en && bus.s_interrup) got_q.push_back(bus.vec_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] irq, input logic mwe, input logic [3:0] md, input logic fin);
        @(negedge clk);
        bus.irq_i        = irq;
        bus.mask_we      = mwe;
        bus.mask_d       = md;
        bus.fin_interrup = fin;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic s, input logic [9:0] vec, input logic [2:0] id,
                           input logic busy, input logic [3:0] pend, input logic [1:0] st);
        chk({tag, ".s_interrup"}, 32'(bus.s_interrup), 32'(s));
        chk({tag, ".vec_addr"},   32'(bus.vec_addr),   32'(vec));
        chk({tag, ".irq_id"},     32'(bus.irq_id),     32'(id));
        chk({tag, ".busy"},       32'(bus.busy),       32'(busy));
        chk({tag, ".pending"},    32'(bus.pending),    32'(pend));
        chk({tag, ".state"},      32'(bus.state_dbg),  32'(st));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0] irq;
        logic       mwe;
        logic [3:0] md;
        logic       fin;
        logic       s;
        logic [9:0] vec;
        logic [2:0] id;
        logic       busy;
        logic [3:0] pend;
        logic [1:0] st;
    } row_t;

    row_t tbl[NROWS];

    initial begin
        //            irq    mwe  md    fin   s    vec      id    busy pend   st
        tbl[0]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        // single source 2
        tbl[1]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h4, 2'd0};
        tbl[2]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3F8, 3'd2, 1'b1, 4'h4, 2'd1};
        tbl[3]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F8, 3'd2, 1'b1, 4'h0, 2'd2};
        tbl[4]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        tbl[5]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        // priority: 1 and 3 together
        tbl[6]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'hA, 2'd0};
        tbl[7]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3F4, 3'd1, 1'b1, 4'hA, 2'd1};
        tbl[8]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F4, 3'd1, 1'b1, 4'h8, 2'd2};
        tbl[9]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h8, 2'd0};
        tbl[10] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3FC, 3'd3, 1'b1, 4'h8, 2'd1};
        tbl[11] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3FC, 3'd3, 1'b1, 4'h0, 2'd2};
        tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        // mask: source 0 masked, latched, then unmasked
        tbl[13] = '{4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        tbl[14] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h1, 2'd0};
        tbl[15] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h1, 2'd0};
        tbl[16] = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h1, 2'd0};
        tbl[17] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3F0, 3'd0, 1'b1, 4'h1, 2'd1};
        tbl[18] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F0, 3'd0, 1'b1, 4'h0, 2'd2};
        tbl[19] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        // level held on source 1: one dispatch only
        tbl[20] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h2, 2'd0};
        tbl[21] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3F4, 3'd1, 1'b1, 4'h2, 2'd1};
        tbl[22] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F4, 3'd1, 1'b1, 4'h0, 2'd2};
        tbl[23] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F4, 3'd1, 1'b1, 4'h0, 2'd2};
        tbl[24] = '{4'h2, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        tbl[25] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        tbl[26] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        // new edge on 1 in the REQ cycle: set beats clear, served again
        tbl[27] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h2, 2'd0};
        tbl[28] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3F4, 3'd1, 1'b1, 4'h2, 2'd1};
        tbl[29] = '{4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F4, 3'd1, 1'b1, 4'h2, 2'd2};
        tbl[30] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h2, 2'd0};
        tbl[31] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3F4, 3'd1, 1'b1, 4'h2, 2'd1};
        tbl[32] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h3F4, 3'd1, 1'b1, 4'h0, 2'd2};
        tbl[33] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        // fin_interrup in IDLE and in REQ is ignored
        tbl[34] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        tbl[35] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h4, 2'd0};
        tbl[36] = '{4'h4, 1'b0, 4'h0, 1'b1, 1'b1, 10'h3F8, 3'd2, 1'b1, 4'h4, 2'd1};
        tbl[37] = '{4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 10'h3F8, 3'd2, 1'b1, 4'h0, 2'd2};
        tbl[38] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
        tbl[39] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n            = 1'b0;
        bus.irq_i        = '0;
        bus.mask_we      = 1'b0;
        bus.mask_d       = '0;
        bus.fin_interrup = 1'b0;
`ifdef UC_INTC_TIMER_EN
        tmr_we = 1'b0;
        tmr_d  = '0;
`endif
        step();
        step();
        chk_out("reset", 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, one row per clock.
        for (int i = 0; i < NROWS; i++) begin
            drive(tbl[i].irq, tbl[i].mwe, tbl[i].md, tbl[i].fin);
            step();
            chk_out($sformatf("row%0d", i), tbl[i].s, tbl[i].vec, tbl[i].id, tbl[i].busy, tbl[i].pend, tbl[i].st);
        end
        exp_q.push_back(10'h3F8);
        exp_q.push_back(10'h3F4);
        exp_q.push_back(10'h3FC);
        exp_q.push_back(10'h3F0);
        exp_q.push_back(10'h3F4);
        exp_q.push_back(10'h3F4);
        exp_q.push_back(10'h3F4);
        exp_q.push_back(10'h3F8);

        // Reset mid-service: source 2 in service, source 0 pending, mask cleared.
        drive(4'h4, 1'b0, 4'h0, 1'b0);
        step();
        drive(4'h4, 1'b0, 4'h0, 1'b0);
        step();
        exp_q.push_back(10'h3F8);
        drive(4'h4, 1'b0, 4'h0, 1'b0);
        step();
        drive(4'h5, 1'b1, 4'h0, 1'b0);
        step();
        chk_out("pre_reset", 1'b0, 10'h3F8, 3'd2, 1'b1, 4'h1, 2'd2);
        drive(4'h0, 1'b0, 4'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0);
        step();
        chk_out("in_reset", 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Mask must be back to all ones: source 3 dispatches without a mask write.
        drive(4'h8, 1'b0, 4'h0, 1'b0);
        step();
        chk_out("post_reset_pend", 1'b0, 10'h000, 3'd0, 1'b0, 4'h8, 2'd0);
        drive(4'h8, 1'b0, 4'h0, 1'b0);
        step();
        chk_out("post_reset_req", 1'b1, 10'h3FC, 3'd3, 1'b1, 4'h8, 2'd1);
        exp_q.push_back(10'h3FC);
        drive(4'h0, 1'b0, 4'h0, 1'b1);
        step();
        drive(4'h0, 1'b0, 4'h0, 1'b1);
        step();
        chk_out("post_reset_ret", 1'b0, 10'h000, 3'd0, 1'b0, 4'h0, 2'd0);

        // Scoreboard: every entry pulse, in order, one cycle each.
        @(negedge clk);
        mon_en = 1'b0;
        chk("pulse_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk("pulse_vec", 32'(g), 32'(e));
        end

`ifdef UC_INTC_TIMER_EN
        begin
            int t_cyc[$];
            int nticks;
            bus.fin_interrup = 1'b0;
            tmr_we = 1'b1;
            tmr_d  = 16'd5;
            @(negedge clk);
            tmr_we = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                bus.fin_interrup = bus.busy && !bus.s_interrup;
                @(posedge clk);
                #1;
                if (bus.s_interrup) begin
                    t_cyc.push_back(c);
                    chk("tmr_id", 32'(bus.irq_id), 32'd0);
                end
            end
            chk("tmr_enough", 32'(t_cyc.size() >= 3), 32'd1);
            if (t_cyc.size() >= 3) begin
                chk("tmr_gap1", 32'(t_cyc[2] - t_cyc[1]), 32'd5);
                chk("tmr_gap0", 32'(t_cyc[1] - t_cyc[0]), 32'd5);
            end
            @(negedge clk);
            tmr_we = 1'b1;
            tmr_d  = 16'd0;
            @(negedge clk);
            tmr_we = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                bus.fin_interrup = bus.busy && !bus.s_interrup;
            end
            nticks = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                bus.fin_interrup = bus.busy && !bus.s_interrup;
                @(posedge clk);
                #1;
                if (bus.s_interrup) nticks++;
            end
            chk("tmr_stopped", 32'(nticks), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
